// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg : opcodes and width helper shared by the ALU back end      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam logic [2:0] OP_PARITY   = 3'b000;
  localparam logic [2:0] OP_POPCOUNT = 3'b001;
  localparam logic [2:0] OP_ROTR     = 3'b010;
  localparam logic [2:0] OP_ROTL     = 3'b011;

  // Bits needed to hold a count of 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_tree.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | popcount_tree : combinational binary adder tree counting ones      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module popcount_tree
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int CNT_W      = cnt_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CNT_W-1:0]      count
);

  localparam int LEVELS = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int LEAVES = 1 << LEVELS;

  // Heap layout: leaves at LEAVES..2*LEAVES-1, node i sums children 2i and 2i+1.
  logic [CNT_W-1:0] node [2*LEAVES];

  always_comb begin
    for (int i = 0; i < 2 * LEAVES; i++) begin
      node[i] = '0;
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      node[LEAVES + i] = CNT_W'(data[i]);
    end
    for (int i = LEAVES - 1; i >= 1; i--) begin
      node[i] = node[2 * i] + node[2 * i + 1];
    end
    count = node[1];
  end

endmodule
`default_nettype wire

// File: rtl/alu_bitops_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_bitops_mux : parity/popcount stages and registered result mux  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module alu_bitops_mux
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            opcode,
  input  logic                  parity_enable,
  input  logic [DATA_WIDTH-1:0] parity_in,
  input  logic                  popcount_enable,
  input  logic [DATA_WIDTH-1:0] popcount_in,
  input  logic [DATA_WIDTH-1:0] rotr_out,
  input  logic [DATA_WIDTH-1:0] rotl_out,
  output logic [DATA_WIDTH-1:0] parity_out,
  output logic [DATA_WIDTH-1:0] popcount_out,
  output logic [DATA_WIDTH-1:0] alu_out
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  logic [CNT_W-1:0]      ones_count;
  logic                  parity_bit;
  logic [DATA_WIDTH-1:0] mux_sel;

  popcount_tree #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_popcount_tree (
    .data  (popcount_in),
    .count (ones_count)
  );

  assign parity_bit = ^parity_in;

  // Every opcode value is decoded so unused codes can never leak X onto alu_out.
  always_comb begin
    mux_sel = '0;
    case (opcode)
      OP_PARITY:   mux_sel = parity_out;
      OP_POPCOUNT: mux_sel = popcount_out;
      OP_ROTR:     mux_sel = rotr_out;
      OP_ROTL:     mux_sel = rotl_out;
      default:     mux_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_out   <= '0;
      popcount_out <= '0;
      alu_out      <= '0;
    end else begin
      if (parity_enable) begin
        parity_out <= DATA_WIDTH'(parity_bit);
      end
      if (popcount_enable) begin
        popcount_out <= DATA_WIDTH'(ones_count);
      end
      alu_out <= mux_sel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_bitops_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_bitops_mux : directed vectors with a reference model        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_alu_bitops_mux;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    opcode;
  logic          parity_enable;
  logic [DW-1:0] parity_in;
  logic          popcount_enable;
  logic [DW-1:0] popcount_in;
  logic [DW-1:0] rotr_out;
  logic [DW-1:0] rotl_out;
  logic [DW-1:0] parity_out;
  logic [DW-1:0] popcount_out;
  logic [DW-1:0] alu_out;

  int errors = 0;
  int checks = 0;

  alu_bitops_mux #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode          (opcode),
    .parity_enable   (parity_enable),
    .parity_in       (parity_in),
    .popcount_enable (popcount_enable),
    .popcount_in     (popcount_in),
    .rotr_out        (rotr_out),
    .rotl_out        (rotl_out),
    .parity_out      (parity_out),
    .popcount_out    (popcount_out),
    .alu_out         (alu_out)
  );

  always #5 clk = ~clk;

  // Reference model: what each output must hold after the latest edge.
  logic [DW-1:0] m_par, m_pop, m_alu, m_next_alu;
  bit            m_valid = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_par   = '0;
      m_pop   = '0;
      m_alu   = '0;
      m_valid = 1;
    end else begin
      if (opcode == 3'd0)      m_next_alu = m_par;
      else if (opcode == 3'd1) m_next_alu = m_pop;
      else if (opcode == 3'd2) m_next_alu = rotr_out;
      else if (opcode == 3'd3) m_next_alu = rotl_out;
      else                     m_next_alu = '0;
      if (parity_enable)   m_par = DW'($countones(parity_in) % 2);
      if (popcount_enable) m_pop = DW'($countones(popcount_in));
      m_alu = m_next_alu;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_parity_out", parity_out, m_par);
      chk("model_popcount_out", popcount_out, m_pop);
      chk("model_alu_out", alu_out, m_alu);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    reset = 1; opcode = 3'($urandom_range(0, 7));
    parity_enable = 1; popcount_enable = 1;
    parity_in = rnd(); popcount_in = rnd(); rotr_out = rnd(); rotl_out = rnd();

    // 1. reset with random inputs
    tick(); tick();
    chk("reset_parity", parity_out, '0);
    chk("reset_popcount", popcount_out, '0);
    chk("reset_alu", alu_out, '0);
    reset = 0; parity_enable = 0; popcount_enable = 0; opcode = 3'b100;
    tick();
    chk("post_reset_parity", parity_out, '0);
    chk("post_reset_popcount", popcount_out, '0);
    chk("post_reset_alu", alu_out, '0);

    // 2. parity
    parity_in = DW'(7); parity_enable = 1; opcode = 3'b000;
    tick();
    chk("parity_0x7_stage", parity_out, DW'(1));
    parity_enable = 0;
    tick();
    chk("parity_0x7_alu", alu_out, DW'(1));
    parity_in = DW'(3); parity_enable = 1;
    tick();
    parity_enable = 0;
    tick();
    chk("parity_0x3_alu", alu_out, '0);

    // 3. popcount values including the all-ones boundary
    popcount_in = '1; popcount_enable = 1; opcode = 3'b001;
    tick();
    popcount_enable = 0;
    tick();
    chk("popcount_all_ones", alu_out, DW'(512));
    popcount_in = '0; popcount_enable = 1;
    tick();
    popcount_enable = 0;
    tick();
    chk("popcount_zero", alu_out, '0);
    popcount_in = DW'(16'hF0F0); popcount_enable = 1;
    tick();
    popcount_enable = 0;
    tick();
    chk("popcount_f0f0", alu_out, DW'(8));

    // 4. hold while enable low
    popcount_in = DW'(8'hFF); popcount_enable = 1;
    tick();
    popcount_enable = 0;
    for (int i = 0; i < 5; i++) begin
      popcount_in = rnd();
      tick();
      chk("popcount_hold", popcount_out, DW'(8));
    end

    // 5. rotate passthrough and unused opcodes
    rotr_out = DW'(8'hA5); rotl_out = DW'(8'h5A);
    opcode = 3'b010;
    tick();
    chk("sel_rotr", alu_out, DW'(8'hA5));
    opcode = 3'b011;
    tick();
    chk("sel_rotl", alu_out, DW'(8'h5A));
    for (int c = 4; c < 8; c++) begin
      opcode = 3'(c);
      tick();
      chk("sel_unused", alu_out, '0);
    end

    // 6. reset priority over enables and opcode, then recovery
    parity_in = DW'(1); popcount_in = DW'(4'hF);
    parity_enable = 1; popcount_enable = 1; opcode = 3'b001;
    tick(); tick();
    chk("pre_reset_alu", alu_out, DW'(4));
    reset = 1;
    tick();
    chk("mid_reset_parity", parity_out, '0);
    chk("mid_reset_popcount", popcount_out, '0);
    chk("mid_reset_alu", alu_out, '0);
    reset = 0;
    tick();
    chk("resume_1clk_alu", alu_out, '0);
    chk("resume_1clk_pop", popcount_out, DW'(4));
    tick();
    chk("resume_2clk_alu", alu_out, DW'(4));

    parity_enable = 0; popcount_enable = 0;
    tick(); tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
